// File: rtl/nios_led_pio_ctrl.sv
// Avalon-MM output PIO for board LEDs: DATA register with set/clear/toggle
// aliases and a per-bit blink engine sharing one programmable half-period.
module nios_led_pio_ctrl #(
   parameter int unsigned WIDTH       = 10,
   parameter int unsigned DIV_W       = 26,
   parameter int unsigned RESET_VALUE = 0,
   parameter int unsigned RESET_DIV   = 24999999
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_BLINK  = 3'd1;
   localparam logic [2:0] ADDR_DIV    = 3'd2;
   localparam logic [2:0] ADDR_OUT    = 3'd3;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;
   localparam logic [2:0] ADDR_OUTTGL = 3'd6;

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] blink_en_q;
   logic [DIV_W-1:0] blink_div_q;
   logic [DIV_W-1:0] cnt_q;
   logic             phase_q;

   logic             wr_en;
   logic [WIDTH-1:0] wd_w;
   logic [DIV_W-1:0] wd_div;
   logic             unused_wd;

   assign wr_en     = chipselect & ~write_n;
   assign wd_w      = writedata[WIDTH-1:0];
   assign wd_div    = writedata[DIV_W-1:0];
   assign unused_wd = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q      <= WIDTH'(RESET_VALUE);
         blink_en_q  <= '0;
         blink_div_q <= DIV_W'(RESET_DIV);
      end else if (wr_en) begin
         case (address)
            ADDR_DATA:   data_q      <= wd_w;
            ADDR_BLINK:  blink_en_q  <= wd_w;
            ADDR_DIV:    blink_div_q <= wd_div;
            ADDR_OUTSET: data_q      <= data_q | wd_w;
            ADDR_OUTCLR: data_q      <= data_q & ~wd_w;
            ADDR_OUTTGL: data_q      <= data_q ^ wd_w;
            default:     ;
         endcase
      end
   end

   // Counter idles at 0/phase=1 while disabled, so enabling from zero
   // always starts a fresh "on" half-period without extra logic.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (wr_en && (address == ADDR_DIV)) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (blink_en_q == '0) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (cnt_q == blink_div_q) begin
         cnt_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         cnt_q   <= cnt_q + DIV_W'(1);
      end
   end

   assign out_port = data_q & (~blink_en_q | {WIDTH{phase_q}});

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:  readdata[WIDTH-1:0] = data_q;
         ADDR_BLINK: readdata[WIDTH-1:0] = blink_en_q;
         ADDR_DIV:   readdata[DIV_W-1:0] = blink_div_q;
         ADDR_OUT:   readdata[WIDTH-1:0] = out_port;
         default:    ;
      endcase
   end

endmodule

// File: tb/tb_nios_led_pio_ctrl.sv
// Directed bench for nios_led_pio_ctrl: expected values are queued as each
// step is driven and popped when the matching output is sampled.
module tb_nios_led_pio_ctrl;

   localparam int WIDTH = 10;
   localparam int DIV_W = 26;
   localparam int RV    = 'h2A5;
   localparam int RDIV  = 24999999;

   logic             clk;
   logic             reset_n;
   logic [2:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] out_port;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];

   nios_led_pio_ctrl #(
      .WIDTH(WIDTH), .DIV_W(DIV_W), .RESET_VALUE(RV), .RESET_DIV(RDIV)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic push(input logic [31:0] v);
      sb_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      total++;
      if (sb_q.size() == 0) begin
         bad++;
         $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
      address = a;
      push(e);
      #1;
      check(tag, readdata);
   endtask

   task automatic chk_out(input logic [31:0] e, input string tag);
      push(e);
      check(tag, {22'd0, out_port});
   endtask

   initial begin
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
      #12;
      chk_out(RV, "rst_out");
      @(negedge clk);
      reset_n = 1'b1;
      rd(3'd0, RV,   "rst_data");
      rd(3'd1, 0,    "rst_blink_en");
      rd(3'd2, RDIV, "rst_div");
      rd(3'd3, RV,   "rst_out_reg");

      wr(3'd0, 32'h00F); chk_out(32'h00F, "data_out"); rd(3'd0, 32'h00F, "data_rd");
      wr(3'd4, 32'h300); chk_out(32'h30F, "set_out");  rd(3'd0, 32'h30F, "set_rd");
      wr(3'd5, 32'h003); chk_out(32'h30C, "clr_out");  rd(3'd0, 32'h30C, "clr_rd");
      wr(3'd6, 32'h3FF); chk_out(32'h0F3, "tgl_out");  rd(3'd0, 32'h0F3, "tgl_rd");
      rd(3'd4, 0, "rd_outset"); rd(3'd5, 0, "rd_outclr");
      rd(3'd6, 0, "rd_outtgl"); rd(3'd7, 0, "rd_rsvd");

      // Blink with half-period 4: on 4, off 4
      wr(3'd2, 3); wr(3'd0, 32'h3FF); wr(3'd1, 1);
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) @(negedge clk);
         chk_out(((k / 4) % 2 == 0) ? 32'h3FF : 32'h3FE, "blink4");
      end
      wr(3'd1, 0);
      chk_out(32'h3FF, "blink_off");

      // Restart: rewrite divider while bit0 is off
      wr(3'd1, 1);
      repeat (4) @(negedge clk);
      chk_out(32'h3FE, "pre_restart_low");
      wr(3'd2, 1);
      for (int s = 0; s < 8; s++) begin
         if (s > 0) @(negedge clk);
         chk_out(((s / 2) % 2 == 0) ? 32'h3FF : 32'h3FE, "blink2");
      end

      wr(3'd2, 0);
      for (int s = 0; s < 6; s++) begin
         if (s > 0) @(negedge clk);
         chk_out((s % 2 == 0) ? 32'h3FF : 32'h3FE, "blink1");
      end

      wr(3'd1, 0);
      wr(3'd0, 32'hFFFF_FFFF);
      rd(3'd0, 32'h3FF, "data_mask");
      rd(3'd1, 0, "en_cleared");
      wr(3'd3, 32'h0); wr(3'd7, 32'h0);
      rd(3'd0, 32'h3FF, "ro_wr_data");
      rd(3'd1, 0, "ro_wr_en");
      rd(3'd2, 0, "ro_wr_div");
      chk_out(32'h3FF, "ro_wr_out");

      // Async reset in the middle of an off half-period
      wr(3'd2, 1); wr(3'd1, 1);
      repeat (2) @(negedge clk);
      chk_out(32'h3FE, "pre_rst_low");
      #2 reset_n = 1'b0;
      #1 chk_out(RV, "async_rst_out");
      rd(3'd1, 0, "async_rst_en");
      @(negedge clk);
      reset_n = 1'b1;
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         chk_out(RV, "post_rst_steady");
      end
      rd(3'd2, RDIV, "post_rst_div");

      if (sb_q.size() != 0) begin
         total++; bad++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
